// File: rtl/fill_pkg.sv
// Shared constants and coordinate/colour types for the screen-fill engine.
`timescale 1ns/1ps
package fill_pkg;

  localparam int unsigned XMAX = 160;
  localparam int unsigned YMAX = 120;
  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CW   = 3;
  localparam int unsigned PW   = XW + YW;

  typedef logic [XW-1:0] xcoord_t;
  typedef logic [YW-1:0] ycoord_t;
  typedef logic [CW-1:0] colour_t;
  typedef logic [PW-1:0] pcount_t;

endpackage

// File: rtl/fill_datapath_if.sv
// Controller/VGA-side signal bundle of the fill datapath; master is the controller side.
`timescale 1ns/1ps
interface fill_datapath_if;
  import fill_pkg::*;

  logic    initx;
  logic    inity;
  logic    loadx;
  logic    loady;
  logic    plot;
  colour_t fill_colour;
  logic    xdone;
  logic    ydone;
  xcoord_t vga_x;
  ycoord_t vga_y;
  colour_t vga_colour;
  logic    vga_plot;
  pcount_t pix_count;
  logic    frame_done;

  modport master (
    output initx, inity, loadx, loady, plot, fill_colour,
    input  xdone, ydone, vga_x, vga_y, vga_colour, vga_plot, pix_count, frame_done
  );

  modport slave (
    input  initx, inity, loadx, loady, plot, fill_colour,
    output xdone, ydone, vga_x, vga_y, vga_colour, vga_plot, pix_count, frame_done
  );

endinterface

// File: rtl/fill_datapath_bounded_counter.sv
// Wrapping up-counter 0..MAX-1 with clear priority and a last-value flag.
`timescale 1ns/1ps
module bounded_counter #(
  parameter int unsigned MAX = 160,
  parameter int unsigned W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         last
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value <= '0;
    else if (init)
      value <= '0;
    else if (inc)
      value <= last ? '0 : value + 1'b1;
  end

  assign last = (value == LAST);

endmodule

// File: rtl/fill_datapath.sv
// Screen-fill datapath: x/y pixel counters, VGA drive, pixel count and sticky frame flag.
// Build option: FILL_COORD_COLOUR_EN replaces fill_colour with an x^y test pattern.
`timescale 1ns/1ps
module fill_datapath
  import fill_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  fill_datapath_if.slave  bus
);

  xcoord_t x;
  ycoord_t y;
  logic    x_last;
  logic    y_last;
  pcount_t pix_count_q;
  logic    frame_done_q;
  logic    frame_clr;

  bounded_counter #(.MAX(XMAX), .W(XW)) u_xcnt (
    .clk   (clk),
    .reset (reset),
    .init  (bus.initx),
    .inc   (bus.loadx),
    .value (x),
    .last  (x_last)
  );

  bounded_counter #(.MAX(YMAX), .W(YW)) u_ycnt (
    .clk   (clk),
    .reset (reset),
    .init  (bus.inity),
    .inc   (bus.loady),
    .value (y),
    .last  (y_last)
  );

  assign frame_clr = bus.initx & bus.inity;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pix_count_q <= '0;
    else if (frame_clr)
      pix_count_q <= '0;
    else if (bus.plot && (pix_count_q != '1))
      pix_count_q <= pix_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      frame_done_q <= 1'b0;
    else if (frame_clr)
      frame_done_q <= 1'b0;
    else if (bus.plot && x_last && y_last)
      frame_done_q <= 1'b1;
  end

  assign bus.xdone      = x_last;
  assign bus.ydone      = y_last;
  assign bus.vga_x      = x;
  assign bus.vga_y      = y;
  assign bus.vga_plot   = bus.plot;
  assign bus.pix_count  = pix_count_q;
  assign bus.frame_done = frame_done_q;

`ifdef FILL_COORD_COLOUR_EN
  assign bus.vga_colour = x[CW-1:0] ^ y[CW-1:0];
`else
  assign bus.vga_colour = bus.fill_colour;
`endif

endmodule

// File: tb/tb_fill_datapath.sv
// Self-checking bench for fill_datapath: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_fill_datapath;
  import fill_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fill_datapath_if bus ();

  fill_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic ix, iy, lx, ly, p;
    int   ex, ey;
    logic exd, eyd;
    int   epix;
    logic efd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ix, input logic iy, input logic lx, input logic ly, input logic p);
    bus.initx = ix;
    bus.inity = iy;
    bus.loadx = lx;
    bus.loady = ly;
    bus.plot  = p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, hits, first_hit, cycles;
    int ex, ey;
    logic last_pix, fd_early;
    logic [CW-1:0] exp_col;

    vt[0] = '{0,0,0,0,0,   0,0, 0,0, 0, 0};
    vt[1] = '{0,0,1,0,0,   1,0, 0,0, 0, 0};
    vt[2] = '{0,0,1,0,1,   2,0, 0,0, 1, 0};
    vt[3] = '{0,0,0,1,0,   2,1, 0,0, 1, 0};
    vt[4] = '{0,0,1,1,1,   3,2, 0,0, 2, 0};
    vt[5] = '{1,0,0,1,0,   0,3, 0,0, 2, 0};
    vt[6] = '{1,0,1,0,0,   0,3, 0,0, 2, 0};
    vt[7] = '{0,1,0,1,1,   0,0, 0,0, 3, 0};
    vt[8] = '{1,1,1,1,1,   0,0, 0,0, 0, 0};
    vt[9] = '{0,0,0,0,1,   0,0, 0,0, 1, 0};

    drive(0, 0, 0, 0, 0);
    bus.fill_colour = 3'b101;
    #12;
    chk("reset_x",    bus.vga_x, 0);
    chk("reset_y",    bus.vga_y, 0);
    chk("reset_pix",  bus.pix_count, 0);
    chk("reset_fd",   bus.frame_done, 0);
    chk("reset_xdone", bus.xdone, 0);
    chk("reset_ydone", bus.ydone, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].ix, vt[i].iy, vt[i].lx, vt[i].ly, vt[i].p);
      tick();
      errs = 0;
      if (bus.vga_x !== XW'(vt[i].ex))        errs++;
      if (bus.vga_y !== YW'(vt[i].ey))        errs++;
      if (bus.xdone !== vt[i].exd)            errs++;
      if (bus.ydone !== vt[i].eyd)            errs++;
      if (bus.pix_count !== PW'(vt[i].epix))  errs++;
      if (bus.frame_done !== vt[i].efd)       errs++;
      if (errs != 0)
        $display("vector %0d: x=%0d y=%0d pix=%0d fd=%0d", i, bus.vga_x, bus.vga_y, bus.pix_count, bus.frame_done);
      chk($sformatf("vec%0d_fields_wrong", i), errs, 0);
    end

    // Asynchronous reset mid-count, asserted between edges.
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    repeat (5) tick();
    drive(0, 0, 1, 0, 1);
    repeat (32) tick();
    chk("pre_rst_x",   bus.vga_x, 37);
    chk("pre_rst_y",   bus.vga_y, 5);
    chk("pre_rst_pix", bus.pix_count, 32);
    drive(0, 0, 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_x",    bus.vga_x, 0);
    chk("async_rst_y",    bus.vga_y, 0);
    chk("async_rst_pix",  bus.pix_count, 0);
    chk("async_rst_fd",   bus.frame_done, 0);
    chk("rst_vga_plot",   bus.vga_plot, 1);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst_vga_plot_lo", bus.vga_plot, 0);
    #2 reset = 1'b1;
    tick();

    // Full init from x=10, y=3.
    drive(0, 0, 1, 1, 1);
    repeat (3) tick();
    drive(0, 0, 1, 0, 1);
    repeat (7) tick();
    chk("setup_x", bus.vga_x, 10);
    chk("setup_y", bus.vga_y, 3);
    drive(1, 1, 1, 1, 0);
    tick();
    chk("init_x",   bus.vga_x, 0);
    chk("init_y",   bus.vga_y, 0);
    chk("init_pix", bus.pix_count, 0);

    // 160 cycles of loadx&plot: xdone only in cycle 160.
    drive(0, 0, 1, 0, 1);
    hits = 0;
    first_hit = 0;
    for (int i = 1; i <= 160; i++) begin
      if (bus.xdone === 1'b1) begin
        hits++;
        if (first_hit == 0) first_hit = i;
      end
      tick();
    end
    chk("xdone_cycle", first_hit, 160);
    chk("xdone_hits",  hits, 1);
    chk("xwrap_x",     bus.vga_x, 0);
    chk("row_pix",     bus.pix_count, 160);

    // Full frame with a controller model.
    drive(1, 1, 1, 1, 0);
    tick();
    bus.fill_colour = 3'b101;
    ex = 0; ey = 0; cycles = 0; errs = 0; last_pix = 1'b0; fd_early = 1'b0;
    while (!last_pix && cycles < 20000) begin
      if (ex != XMAX - 1)      drive(0, 0, 1, 0, 1);
      else if (ey != YMAX - 1) drive(1, 0, 0, 1, 1);
      else begin
        drive(0, 0, 0, 0, 1);
        last_pix = 1'b1;
      end
      #1;
      if (bus.vga_x !== XW'(ex))                  errs++;
      if (bus.vga_y !== YW'(ey))                  errs++;
      if (bus.xdone !== (ex == XMAX - 1))         errs++;
      if (bus.ydone !== (ey == YMAX - 1))         errs++;
      if (bus.vga_plot !== 1'b1)                  errs++;
`ifdef FILL_COORD_COLOUR_EN
      exp_col = CW'(ex) ^ CW'(ey);
`else
      exp_col = 3'b101;
`endif
      if (bus.vga_colour !== exp_col)             errs++;
      if (bus.frame_done !== 1'b0)                fd_early = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
      if (!last_pix) begin
        if (ex != XMAX - 1) ex++;
        else begin
          ex = 0;
          ey++;
        end
      end
    end
    chk("frame_cycles",   cycles, 19200);
    chk("frame_errs",     errs, 0);
    chk("frame_fd_early", fd_early, 0);
    chk("frame_fd",       bus.frame_done, 1);
    chk("frame_pix",      bus.pix_count, 19200);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("frame_fd_sticky", bus.frame_done, 1);

    // Plot at last pixel on the same edge as a full clear.
    drive(1, 1, 0, 0, 0);
    tick();
    chk("clr_fd", bus.frame_done, 0);
    for (int i = 0; i < 159; i++) begin
      drive(0, 0, 1, (i < 119), 0);
      tick();
    end
    chk("corner_xdone", bus.xdone, 1);
    chk("corner_ydone", bus.ydone, 1);
    drive(1, 1, 0, 0, 1);
    tick();
    chk("collide_fd",  bus.frame_done, 0);
    chk("collide_pix", bus.pix_count, 0);
    chk("collide_x",   bus.vga_x, 0);

    // Saturation of pix_count.
    drive(0, 0, 0, 0, 1);
    repeat (32767) tick();
    chk("sat_pix", bus.pix_count, 32767);
    tick();
    chk("sat_hold", bus.pix_count, 32767);

    // Colour source at x=6, y=3.
    drive(1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, (i < 3), 0);
      tick();
    end
    bus.fill_colour = 3'b010;
    drive(0, 0, 0, 0, 0);
    #1;
`ifdef FILL_COORD_COLOUR_EN
    chk("colour_pattern", bus.vga_colour, 3'b101);
`else
    chk("colour_fill", bus.vga_colour, 3'b010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
